// File: rtl/uwasic_onboarding_pkg.sv
// Shared constants, register map and types for the onboarding tile.
`timescale 1ns/1ps
package uwasic_onboarding_pkg;

  localparam int unsigned REG_W           = 8;
  localparam int unsigned ADDR_W          = 7;
  localparam int unsigned FRAME_BITS      = 16;
  localparam int unsigned CNT_W           = $clog2(FRAME_BITS + 1);
  localparam int unsigned N_CH            = 16;
  localparam int unsigned PRESCALE_DEF    = 13;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ADDR_EN_OUT_LO = 7'h00;
  localparam reg_addr_t ADDR_EN_OUT_HI = 7'h01;
  localparam reg_addr_t ADDR_EN_PWM_LO = 7'h02;
  localparam reg_addr_t ADDR_EN_PWM_HI = 7'h03;
  localparam reg_addr_t ADDR_DUTY      = 7'h04;
  localparam reg_addr_t MAX_ADDR       = 7'h04;

  typedef struct packed {
    logic [N_CH-1:0]  en_out;
    logic [N_CH-1:0]  en_pwm;
    logic [REG_W-1:0] duty;
  } ctrl_regs_t;

  // A frame commits only when complete, a write, and inside the register map.
  function automatic logic frame_ok(input logic [CNT_W-1:0] cnt, input logic rw,
                                    input reg_addr_t addr);
    return (cnt == CNT_W'(FRAME_BITS)) && rw && (addr <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/uwasic_onboarding_if.sv
// Tiny Tapeout user-tile pin bundle; slave side is the design.
`timescale 1ns/1ps
interface uwasic_onboarding_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/uwasic_onboarding_spi_peripheral.sv
// Write-only SPI mode-0 peripheral: input sync, 16-bit frame shift, register commit.
`timescale 1ns/1ps
module uwasic_onboarding_spi_peripheral
  import uwasic_onboarding_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output ctrl_regs_t regs_o
);

  // Bit order {ncs, copi, sclk}; nCS idles high so reset does not fake an edge.
  localparam logic [2:0] SYNC_RST = 3'b100;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  ctrl_regs_t                  regs_q, regs_d;

  logic      sclk_s, copi_s, ncs_s;
  logic      sclk_rise_c, ncs_fall_c, ncs_rise_c;
  reg_addr_t addr_c;
  logic      rw_c;
  logic [REG_W-1:0] data_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
      prev_q <= SYNC_RST;
    end else begin
      sync_q[0] <= {ncs_i, copi_i, sclk_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sync_q[SYNC_STAGES-1][0];
  assign copi_s      = sync_q[SYNC_STAGES-1][1];
  assign ncs_s       = sync_q[SYNC_STAGES-1][2];
  assign sclk_rise_c = sclk_s & ~prev_q[0];
  assign ncs_fall_c  = ~ncs_s & prev_q[2];
  assign ncs_rise_c  = ncs_s & ~prev_q[2];

  assign rw_c   = shift_q[FRAME_BITS-1];
  assign addr_c = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign data_c = shift_q[REG_W-1:0];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    if (ncs_fall_c) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (!ncs_s && sclk_rise_c && (cnt_q < CNT_W'(FRAME_BITS))) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (ncs_rise_c && frame_ok(cnt_q, rw_c, addr_c)) begin
      case (addr_c)
        ADDR_EN_OUT_LO: regs_d.en_out[7:0]  = data_c;
        ADDR_EN_OUT_HI: regs_d.en_out[15:8] = data_c;
        ADDR_EN_PWM_LO: regs_d.en_pwm[7:0]  = data_c;
        ADDR_EN_PWM_HI: regs_d.en_pwm[15:8] = data_c;
        ADDR_DUTY:      regs_d.duty         = data_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      regs_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/uwasic_onboarding_top.sv
// Onboarding tile top: SPI-programmed 16-channel PWM/static output driver.
// Define PWM_DUTY_SYNC_EN to apply duty changes only at the PWM period boundary.
`timescale 1ns/1ps
module uwasic_onboarding_top
  import uwasic_onboarding_pkg::*;
#(
  parameter int unsigned PRESCALE    = PRESCALE_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  uwasic_onboarding_if.slave  tt_if
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);

  ctrl_regs_t       regs;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [7:0]       duty_c;
  logic             pre_wrap_c, pwm_c;
  logic             unused_c;

  uwasic_onboarding_spi_peripheral #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (tt_if.ui_in[0]),
    .copi_i (tt_if.ui_in[1]),
    .ncs_i  (tt_if.ui_in[2]),
    .regs_o (regs)
  );

  always_comb begin
    pre_wrap_c = (pre_q == PRE_W'(PRESCALE - 1));
    pre_d      = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
    pwm_cnt_d  = pwm_cnt_q + 8'(pre_wrap_c);
  end

`ifdef PWM_DUTY_SYNC_EN
  logic [7:0] duty_q, duty_d;
  // Active duty follows the SPI shadow only as the counter wraps 255 -> 0.
  assign duty_d = (pre_wrap_c && (pwm_cnt_q == 8'hFF)) ? regs.duty : duty_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_q <= '0;
    else     duty_q <= duty_d;
  end
  assign duty_c = duty_q;
`else
  assign duty_c = regs.duty;
`endif

  always_comb begin
    pwm_c = (duty_c == 8'hFF) || (pwm_cnt_q < duty_c);
    out_d = regs.en_out & (~regs.en_pwm | {N_CH{pwm_c}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign tt_if.uo_out  = out_q[7:0];
  assign tt_if.uio_out = out_q[15:8];
  assign tt_if.uio_oe  = 8'hFF;
  assign unused_c      = &{1'b0, tt_if.ena, tt_if.uio_in, tt_if.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_top.sv
// Randomized SPI-frame bench for the onboarding tile, compared every cycle to a pin-level model.
`timescale 1ns/1ps
module tb_uwasic_onboarding_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [4:0] ui_hi = 5'h0;
  int         checks = 0, failures = 0;
  int         ncyc = 0;
  bit         quiet = 1'b0, chk_en = 1'b0;
  logic [7:0] m_reg [5];

  uwasic_onboarding_if bus ();

  uwasic_onboarding_top dut (
    .clk   (clk),
    .rst   (rst),
    .tt_if (bus)
  );

  assign bus.ui_in = {ui_hi, ncs, copi, sclk};

  always #50 clk = ~clk;

  always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

  // Expected pins after n clock edges out of reset: PWM step = (n-1)/13 mod 256.
  function automatic logic [15:0] exp_out(input int n);
    logic [15:0] e, eo, ep;
    int c;
    logic p;
    e = 16'h0;
    if (n < 1) return e;
    c  = ((n - 1) / 13) % 256;
    eo = {m_reg[1], m_reg[0]};
    ep = {m_reg[3], m_reg[2]};
    p  = (m_reg[4] == 8'hFF) || (c < int'(m_reg[4]));
    for (int i = 0; i < 16; i++) if (eo[i]) e[i] = ep[i] ? p : 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en && !rst && !quiet)
      check("cycle_out", {8'h0, bus.uio_oe, bus.uio_out, bus.uo_out}, {8'h0, 8'hFF, exp_out(ncyc)});
  end

  // The first 16 bits shifted define the frame; commits follow the write/address rules.
  task automatic spi_send(input logic [31:0] bits, input int nbits);
    logic [15:0] f;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = bits[31-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs   = 1'b1;
    quiet = 1'b1;
    repeat (8) @(negedge clk);
    f = bits[31:16];
    if (nbits >= 16 && f[15] && f[14:8] <= 7'h04) m_reg[f[10:8]] = f[7:0];
    quiet = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_send({1'b1, a, d, 16'h0}, 16);
  endtask

  task automatic wait_lvl(input logic v, output int t);
    t = -1;
    for (int k = 0; k < 8000 && t < 0; k++) begin
      @(negedge clk);
      if (bus.uo_out[0] === v) t = ncyc;
    end
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r1, f1, r2, hi, lo, bad;
    logic [31:0] bits;
    int nb;
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_uo_out", 32'(bus.uo_out), 32'h00);
    check("rst_uio_out", 32'(bus.uio_out), 32'h00);
    check("rst_uio_oe", 32'(bus.uio_oe), 32'hFF);
    chk_en = 1'b1;
    rst    = 1'b0;
    repeat (4) @(negedge clk);

    // Static enables
    wr(7'h00, 8'hF0);
    wr(7'h01, 8'hCC);
    check("static_uo", 32'(bus.uo_out), 32'hF0);
    check("static_uio", 32'(bus.uio_out), 32'hCC);

    // Frames that must be discarded
    spi_send({1'b1, 7'h30, 8'hFF, 16'h0}, 16);
    check("bad_addr30", 32'({bus.uio_out, bus.uo_out}), 32'hCCF0);
    spi_send({1'b1, 7'h00, 8'h0F, 16'h0}, 15);
    check("short15", 32'({bus.uio_out, bus.uo_out}), 32'hCCF0);
    spi_send({1'b0, 7'h01, 8'h00, 16'h0}, 16);
    check("read_frame", 32'({bus.uio_out, bus.uo_out}), 32'hCCF0);
    spi_send({1'b1, 7'h05, 8'hFF, 16'h0}, 16);
    check("addr05", 32'({bus.uio_out, bus.uo_out}), 32'hCCF0);

    // Bits beyond 16 are ignored
    spi_send({1'b1, 7'h01, 8'h3C, 4'hF, 12'h0}, 20);
    check("extra_bits", 32'(bus.uio_out), 32'h3C);

    // 50% PWM on channel 0
    wr(7'h00, 8'h01); wr(7'h01, 8'h00); wr(7'h02, 8'h01); wr(7'h03, 8'h00); wr(7'h04, 8'h80);
    wait_lvl(1'b0, t0); wait_lvl(1'b1, r1); wait_lvl(1'b0, f1); wait_lvl(1'b1, r2);
    check("pwm50_edges_found", 32'(t0 >= 0 && r1 >= 0 && f1 >= 0 && r2 >= 0), 32'h1);
    check_rng("pwm50_period", r2 - r1, 3326, 3330);
    check_rng("pwm50_high", f1 - r1, 1651, 1677);

    // Duty extremes over three periods
    wr(7'h04, 8'h00);
    hi = 0;
    for (int k = 0; k < 3 * 3328; k++) begin @(negedge clk); if (bus.uo_out[0]) hi++; end
    check("duty00_highs", 32'(hi), 32'h0);
    wr(7'h04, 8'hFF);
    lo = 0;
    for (int k = 0; k < 3 * 3328; k++) begin @(negedge clk); if (!bus.uo_out[0]) lo++; end
    check("dutyFF_lows", 32'(lo), 32'h0);

    // Mixed channels: ch0 at 25%, all others static high
    wr(7'h00, 8'hFF); wr(7'h01, 8'hFF); wr(7'h02, 8'h01); wr(7'h03, 8'h00); wr(7'h04, 8'h40);
    hi = 0; bad = 0;
    for (int k = 0; k < 3328; k++) begin
      @(negedge clk);
      if (bus.uo_out[0]) hi++;
      if (bus.uo_out[7:1] !== 7'h7F || bus.uio_out !== 8'hFF) bad++;
    end
    check("mixed_ch0_high", 32'(hi), 32'd832);
    check("mixed_static_bad", 32'(bad), 32'h0);

    // Random frames, including invalid addresses, reads and odd lengths
    for (int r = 0; r < 25; r++) begin
      bits = $urandom;
      bits[31]    = ($urandom_range(0, 3) != 0);
      bits[30:24] = 7'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: nb = 15;
        3: nb = 20;
        default: nb = 16;
      endcase
      ui_hi = 5'($urandom);
      spi_send(bits, nb);
    end

    // Reset in the middle of a frame
    wr(7'h01, 8'hFF); wr(7'h03, 8'h00);
    check("pre_rst_uio", 32'(bus.uio_out), 32'hFF);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      copi = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    @(negedge clk);
    check("midrst_uo", 32'(bus.uo_out), 32'h00);
    check("midrst_uio", 32'(bus.uio_out), 32'h00);
    check("midrst_oe", 32'(bus.uio_oe), 32'hFF);
    repeat (3) @(negedge clk);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_out", 32'({bus.uio_out, bus.uo_out}), 32'h0);
    wr(7'h00, 8'h5A);
    check("post_rst_write", 32'({bus.uio_out, bus.uo_out}), 32'h005A);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
